// File: rtl/lane_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lane_pkg
//  Description : Shared constants, state encoding and frame-length clamp for
//                the byte lane distributor.
//  Revision    : 1.0 - initial release
// ============================================================================
package lane_pkg;

    localparam int unsigned NUM_LANES = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LIDX_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2
    } dist_state_t;

    // Map a requested lane count onto the legal range 1..num_lanes;
    // zero or oversize requests mean "use every lane".
    function automatic int unsigned clamp_len(input int unsigned active_lanes,
                                              input int unsigned num_lanes = NUM_LANES);
        return ((active_lanes == 0) || (active_lanes > num_lanes)) ? num_lanes : active_lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane_distributor_if.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_distributor_if
//  Description : Serial byte stream (valid/ready/last) feeding the lane
//                distributor. master = byte producer, slave = distributor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface byte_lane_distributor_if #(
    parameter int unsigned DATA_W = lane_pkg::DATA_W
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    modport master (output s_valid, output s_data, output s_last, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface
`default_nettype wire

// File: rtl/lane_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : lane_onehot_dec
//  Description : Lane index to one-hot strobe decoder with enable; all-zero
//                output when disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_onehot_dec #(
    parameter int unsigned LIDX_W    = 4,
    parameter int unsigned NUM_LANES = 16
) (
    input  wire logic                 i_en,
    input  wire logic [LIDX_W-1:0]    i_idx,
    output logic      [NUM_LANES-1:0] o_onehot
);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        // Each lane strobe compares the index against its own position.
        assign o_onehot[k] = i_en && (i_idx == LIDX_W'(k));
    end

endmodule
`default_nettype wire

// File: rtl/byte_lane_distributor.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_distributor
//  Description : Turns a serial valid/ready byte stream into per-lane byte
//                writes with a one-hot lane strobe. Supports a per-frame lane
//                count, early termination with optional zero padding, and a
//                downstream hold that freezes all activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_distributor #(
    parameter int unsigned NUM_LANES = lane_pkg::NUM_LANES,
    parameter int unsigned DATA_W    = lane_pkg::DATA_W,
    parameter int unsigned LIDX_W    = lane_pkg::LIDX_W
) (
    input  wire logic                          clk,
    input  wire logic                          reset_n,
    byte_lane_distributor_if.slave             s,
    input  wire logic [LIDX_W:0]               active_lanes,
    input  wire logic                          pad_en,
    input  wire logic                          hold,
    output logic      [NUM_LANES*DATA_W-1:0]   lane_data,
    output logic      [NUM_LANES-1:0]          valid_data,
    output logic                               frame_done,
    output logic      [15:0]                   frame_cnt
);
    import lane_pkg::*;

    localparam int unsigned c_LEN_W = LIDX_W + 1;

    dist_state_t                  state_q,      state_d;
    logic [LIDX_W-1:0]            lane_idx_q,   lane_idx_d;
    logic [c_LEN_W-1:0]           len_q,        len_d;
    logic [NUM_LANES*DATA_W-1:0]  lane_data_q,  lane_data_d;
    logic [NUM_LANES-1:0]         valid_data_q, valid_data_d;
    logic                         frame_done_q, frame_done_d;
    logic [15:0]                  frame_cnt_q,  frame_cnt_d;

    logic                         w_accept;
    logic                         w_wr_en;
    logic [DATA_W-1:0]            w_wr_byte;
    logic                         w_complete;
    logic                         w_last_lane;
    logic [c_LEN_W-1:0]           w_len;
    logic [NUM_LANES-1:0]         w_onehot;

    // Ready drops during reset, hold, and while padding owns the lanes.
    assign s.s_ready   = reset_n && !hold && (state_q != PAD);
    assign w_accept    = s.s_valid && s.s_ready;
    assign w_len       = c_LEN_W'(clamp_len(32'(active_lanes), NUM_LANES));
    assign w_last_lane = ({1'b0, lane_idx_q} == (len_q - c_LEN_W'(1)));

    // Frame sequencing: which lane to write, what to write, and when the frame ends.
    always_comb begin
        state_d     = state_q;
        lane_idx_d  = lane_idx_q;
        len_d       = len_q;
        frame_cnt_d = frame_cnt_q;
        w_wr_en     = 1'b0;
        w_wr_byte   = '0;
        w_complete  = 1'b0;

        if (!hold) begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        w_wr_en   = 1'b1;
                        w_wr_byte = s.s_data;
                        len_d     = w_len;
                        if (w_len == c_LEN_W'(1)) begin
                            w_complete = 1'b1;
                        end else if (s.s_last) begin
                            if (pad_en) begin
                                state_d    = PAD;
                                lane_idx_d = LIDX_W'(1);
                            end else begin
                                w_complete = 1'b1;
                            end
                        end else begin
                            state_d    = FILL;
                            lane_idx_d = LIDX_W'(1);
                        end
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        w_wr_en   = 1'b1;
                        w_wr_byte = s.s_data;
                        if (w_last_lane) begin
                            w_complete = 1'b1;
                        end else if (s.s_last) begin
                            if (pad_en) begin
                                state_d    = PAD;
                                lane_idx_d = lane_idx_q + LIDX_W'(1);
                            end else begin
                                w_complete = 1'b1;
                            end
                        end else begin
                            lane_idx_d = lane_idx_q + LIDX_W'(1);
                        end
                    end
                end
                PAD: begin
                    w_wr_en   = 1'b1;
                    if (w_last_lane) begin
                        w_complete = 1'b1;
                    end else begin
                        lane_idx_d = lane_idx_q + LIDX_W'(1);
                    end
                end
                default: begin
                    state_d    = IDLE;
                    lane_idx_d = '0;
                end
            endcase
        end

        if (w_complete) begin
            state_d     = IDLE;
            lane_idx_d  = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    lane_onehot_dec #(
        .LIDX_W    (LIDX_W),
        .NUM_LANES (NUM_LANES)
    ) u_strobe_dec (
        .i_en     (w_wr_en),
        .i_idx    (lane_idx_q),
        .o_onehot (w_onehot)
    );

    // Only the strobed lane takes the new byte; every other lane keeps its value.
    always_comb begin
        lane_data_d  = lane_data_q;
        valid_data_d = w_onehot;
        frame_done_d = w_complete;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (w_onehot[k]) begin
                lane_data_d[k*DATA_W +: DATA_W] = w_wr_byte;
            end
        end
    end

    // State and registered outputs; asynchronous reset discards any partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            lane_idx_q   <= '0;
            len_q        <= '0;
            lane_data_q  <= '0;
            valid_data_q <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            lane_idx_q   <= lane_idx_d;
            len_q        <= len_d;
            lane_data_q  <= lane_data_d;
            valid_data_q <= valid_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign lane_data  = lane_data_q;
    assign valid_data = valid_data_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire
